dm_hs: RTL and testbench

Parametrised data memory with a valid/ready request port. Supports sub-word access: byte, halfword and word loads and stores. Loads can be sign- or zero-extended, and misaligned or out-of-range requests raise a fault. Read latency is configurable, and the array is cleared in hardware after reset. It sits in the MEM stage behind the pipeline's memory-request logic and replaces the fixed single-cycle data memory.

---
 rtl/dm_hs_if.sv | 25 ++
 rtl/dm_hs.sv | 166 ++++++++++++++++
 tb/tb_dm_hs.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_hs_if.sv
// Request/response bundle between the MEM-stage request logic (master) and dm_hs (slave).
`timescale 1ns/1ps
interface dm_hs_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/dm_hs.sv
// Data memory with valid/ready request port, sub-word access, faults and configurable load latency.
// Optional store trace is enabled by defining DM_STORE_TRACE_EN.
`timescale 1ns/1ps
module dm_hs #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic   clk,
  input  logic   reset,
  dm_hs_if.slave bus
);
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] LAT_M1   = 2'(RD_LAT - 1);

  logic [31:0]       mem [DEPTH];
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       rd_word_q;
  logic [1:0]        size_q, off_q;
  logic              uns_q, we_q, fault_q;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic              accept, fault, store_commit;
  logic [ADDR_W-1:0] word_idx, wr_idx;
  logic [3:0]        req_be, wr_be;
  logic [31:0]       req_lanes, wr_data, shifted, load_ext;

  assign accept       = bus.req_valid && (state_q == ST_IDLE);
  assign word_idx     = bus.req_addr[ADDR_W+1:2];
  assign store_commit = accept && bus.req_we && !fault;

  always_comb begin
    fault = 1'b0;
    if (bus.req_size == 2'b11)                                 fault = 1'b1;
    else if (bus.req_size == 2'b01 && bus.req_addr[0])         fault = 1'b1;
    else if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) fault = 1'b1;
    else if (bus.req_addr[31:ADDR_W+2] != '0)                  fault = 1'b1;
  end

  always_comb begin
    case (bus.req_size)
      2'b00:   req_be = 4'b0001 << bus.req_addr[1:0];
      2'b01:   req_be = bus.req_addr[1] ? 4'b1100 : 4'b0011;
      default: req_be = 4'b1111;
    endcase
  end

  // Store data replicated across lanes so the byte enables alone pick the destination.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign req_lanes[gi*8 +: 8] = (bus.req_size == 2'b00) ? bus.req_wdata[7:0] :
                                  (bus.req_size == 2'b01) ? bus.req_wdata[(gi%2)*8 +: 8] :
                                                            bus.req_wdata[gi*8 +: 8];
  end

  assign wr_be   = (state_q == ST_CLEAR) ? 4'b1111 : (store_commit ? req_be : 4'b0000);
  assign wr_idx  = (state_q == ST_CLEAR) ? clr_q : word_idx;
  assign wr_data = (state_q == ST_CLEAR) ? 32'h0 : req_lanes;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
    end
    if (accept) rd_word_q <= mem[word_idx];
  end

  assign shifted = rd_word_q >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_fault_d = 1'b0;
    rsp_rdata_d = 32'h0;
    case (state_q)
      ST_CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == {ADDR_W{1'b1}}) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BUSY;
          cnt_d   = (fault || bus.req_we) ? 2'd0 : LAT_M1;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 2'd0) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_fault_d = fault_q;
          rsp_rdata_d = (fault_q || we_q) ? 32'h0 : load_ext;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_CLEAR;
      clr_q       <= '0;
      cnt_q       <= 2'd0;
      size_q      <= 2'd0;
      off_q       <= 2'd0;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      fault_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (accept) begin
        size_q  <= bus.req_size;
        off_q   <= bus.req_addr[1:0];
        uns_q   <= bus.req_unsigned;
        we_q    <= bus.req_we;
        fault_q <= fault;
      end
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.rsp_rdata = rsp_rdata_q;

`ifdef DM_STORE_TRACE_EN
  logic [31:0] trace_word;
  always_comb begin
    trace_word = mem[word_idx];
    for (int i = 0; i < 4; i++) begin
      if (req_be[i]) trace_word[i*8 +: 8] = req_lanes[i*8 +: 8];
    end
  end
  always_ff @(posedge clk) begin
    if (store_commit)
      $display("%d@%h: *%h <= %h", $time, bus.req_pc, {bus.req_addr[31:2], 2'b00}, trace_word);
  end
`else
  logic unused_pc;
  assign unused_pc = ^bus.req_pc;
`endif

endmodule

// File: tb/tb_dm_hs.sv
// Randomized and directed bench for dm_hs against a byte-addressed reference memory.
`timescale 1ns/1ps
module tb_dm_hs;
  localparam int ADDR_W = 4;
  localparam int RD_LAT = 3;
  localparam int DEPTH  = 16;
  localparam int NBYTES = 64;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dm_hs_if bus();
  dm_hs #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] bytes_m [NBYTES];

  // Reference: little-endian byte memory, loads assembled and extended arithmetically.
  task automatic model_req(input req_t r, output logic [31:0] rd, output logic flt, output int lat);
    int n;
    longint v;
    flt = (r.size == 2'd3) || (r.size == 2'd1 && r.addr % 2 != 0) ||
          (r.size == 2'd2 && r.addr % 4 != 0) || (r.addr >= NBYTES);
    rd  = 32'h0;
    lat = 1;
    if (flt) return;
    n = 1 << r.size;
    if (r.we) begin
      for (int i = 0; i < n; i++) bytes_m[6'(r.addr + i)] = 8'(r.wdata >> (8 * i));
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(bytes_m[6'(r.addr + i)]) << (8 * i);
      if (!r.uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
      rd  = 32'(v);
      lat = RD_LAT;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBYTES; i++) bytes_m[i] = 8'h00;
  endtask

  // Drives one request from a negedge; returns at the negedge of the response cycle.
  task automatic issue(input req_t r, output logic [31:0] rd, output logic flt, output int lat,
                       output bit ready_in_busy, output int waited);
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    rd = 32'hx; flt = 1'bx; lat = -1; ready_in_busy = 1'b0;
    if (bus.req_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: req_ready=%b after %0d cycles, required 1", bus.req_ready, waited);
      return;
    end
    bus.req_valid    = 1'b1;
    bus.req_we       = r.we;
    bus.req_size     = r.size;
    bus.req_unsigned = r.uns;
    bus.req_addr     = r.addr;
    bus.req_wdata    = r.wdata;
    bus.req_pc       = $urandom;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      if (bus.req_ready !== 1'b0) ready_in_busy = 1'b1;
      @(negedge clk);
      lat++;
    end
    rd  = bus.rsp_rdata;
    flt = bus.rsp_fault;
    $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h fault=%b lat=%0d",
             r.we, r.size, r.uns, r.addr, r.wdata, rd, flt, lat);
  endtask

  task automatic test_reset();
    req_t r;
    logic [31:0] e_rd, g_rd;
    logic e_flt, g_flt;
    int e_lat, g_lat, w, n;
    bit rib;
    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.req_pc = 32'h0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_fault} !== 3'b000 || bus.rsp_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b valid=%b fault=%b rdata=%h, required all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_fault, bus.rsp_rdata);
    end
    reset = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n !== DEPTH) begin
      miscompares++;
      $display("FAIL reset_sweep: req_ready low for %0d cycles, required %0d", n, DEPTH);
    end
    model_clear();
    r = '{1'b0, 2'd2, 1'b0, 32'h3C, 32'h0};
    model_req(r, e_rd, e_flt, e_lat);
    issue(r, g_rd, g_flt, g_lat, rib, w);
    vectors++;
    if (g_rd !== 32'h0 || g_rd !== e_rd || g_flt !== e_flt || g_lat !== e_lat) begin
      miscompares++;
      $display("FAIL reset_load15: got rdata=%h fault=%b lat=%0d, required rdata=%h fault=%b lat=%0d",
               g_rd, g_flt, g_lat, e_rd, e_flt, e_lat);
    end
  endtask

  task automatic test_store_merge();
    req_t t [3];
    logic [31:0] e_rd, g_rd;
    logic e_flt, g_flt;
    int e_lat, g_lat, w;
    bit rib;
    t = '{'{1'b1, 2'd2, 1'b0, 32'h8, 32'h12345678},
          '{1'b1, 2'd0, 1'b0, 32'hA, 32'h000000AB},
          '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0}};
    foreach (t[i]) begin
      model_req(t[i], e_rd, e_flt, e_lat);
      issue(t[i], g_rd, g_flt, g_lat, rib, w);
      vectors++;
      if (g_rd !== e_rd || g_flt !== e_flt || g_lat !== e_lat) begin
        miscompares++;
        $display("FAIL merge_%0d: got rdata=%h fault=%b lat=%0d, required rdata=%h fault=%b lat=%0d",
                 i, g_rd, g_flt, g_lat, e_rd, e_flt, e_lat);
      end
    end
    vectors++;
    if (g_rd !== 32'h12AB5678) begin
      miscompares++;
      $display("FAIL merge_word: got %h, required 12ab5678", g_rd);
    end
  endtask

  task automatic test_extend();
    req_t t [5];
    logic [31:0] lit [5];
    logic [31:0] e_rd, g_rd;
    logic e_flt, g_flt;
    int e_lat, g_lat, w;
    bit rib;
    t = '{'{1'b1, 2'd2, 1'b0, 32'h0, 32'h80FF7F01},
          '{1'b0, 2'd0, 1'b0, 32'h2, 32'h0},
          '{1'b0, 2'd0, 1'b1, 32'h2, 32'h0},
          '{1'b0, 2'd1, 1'b0, 32'h2, 32'h0},
          '{1'b0, 2'd1, 1'b1, 32'h0, 32'h0}};
    lit = '{32'h0, 32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01};
    foreach (t[i]) begin
      model_req(t[i], e_rd, e_flt, e_lat);
      issue(t[i], g_rd, g_flt, g_lat, rib, w);
      vectors++;
      if (g_rd !== e_rd || g_rd !== lit[i] || g_flt !== e_flt || g_lat !== e_lat) begin
        miscompares++;
        $display("FAIL extend_%0d: got rdata=%h fault=%b lat=%0d, required rdata=%h fault=%b lat=%0d",
                 i, g_rd, g_flt, g_lat, lit[i], e_flt, e_lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    req_t r;
    logic [31:0] e_rd, g_rd;
    logic e_flt, g_flt;
    int e_lat, g_lat, w;
    bit rib;
    r = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0};
    model_req(r, e_rd, e_flt, e_lat);
    issue(r, g_rd, g_flt, g_lat, rib, w);
    vectors++;
    if (g_lat !== RD_LAT || rib !== 1'b0 || g_rd !== e_rd) begin
      miscompares++;
      $display("FAIL load_latency: got lat=%0d ready_in_busy=%b rdata=%h, required lat=%0d ready_in_busy=0 rdata=%h",
               g_lat, rib, g_rd, RD_LAT, e_rd);
    end
    r = '{1'b1, 2'd1, 1'b0, 32'hE, 32'h0000C0DE};
    model_req(r, e_rd, e_flt, e_lat);
    issue(r, g_rd, g_flt, g_lat, rib, w);
    vectors++;
    if (w !== 0 || g_lat !== 1 || g_rd !== 32'h0 || g_flt !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_store: got wait=%0d lat=%0d rdata=%h fault=%b, required wait=0 lat=1 rdata=0 fault=0",
               w, g_lat, g_rd, g_flt);
    end
  endtask

  task automatic test_faults();
    req_t t [9];
    logic [31:0] e_rd, g_rd;
    logic e_flt, g_flt;
    int e_lat, g_lat, w;
    bit rib;
    t = '{'{1'b1, 2'd1, 1'b0, 32'h1,     32'hFFFFFFFF},
          '{1'b0, 2'd2, 1'b0, 32'h6,     32'h0},
          '{1'b0, 2'd3, 1'b0, 32'h0,     32'h0},
          '{1'b0, 2'd2, 1'b0, 32'h10000, 32'h0},
          '{1'b1, 2'd2, 1'b0, 32'h10000, 32'hA5A5A5A5},
          '{1'b0, 2'd2, 1'b0, 32'h0,     32'h0},
          '{1'b0, 2'd2, 1'b0, 32'h4,     32'h0},
          '{1'b0, 2'd2, 1'b0, 32'h8,     32'h0},
          '{1'b0, 2'd2, 1'b0, 32'hC,     32'h0}};
    foreach (t[i]) begin
      model_req(t[i], e_rd, e_flt, e_lat);
      issue(t[i], g_rd, g_flt, g_lat, rib, w);
      vectors++;
      if (g_rd !== e_rd || g_flt !== e_flt || g_lat !== e_lat || (i < 5 && g_flt !== 1'b1)) begin
        miscompares++;
        $display("FAIL fault_%0d: got rdata=%h fault=%b lat=%0d, required rdata=%h fault=%b lat=%0d",
                 i, g_rd, g_flt, g_lat, e_rd, e_flt, e_lat);
      end
    end
  endtask

  task automatic test_reset_busy();
    req_t r;
    logic [31:0] e_rd, g_rd;
    logic e_flt, g_flt;
    int e_lat, g_lat, w, n;
    bit rib, saw_rsp;
    r = '{1'b1, 2'd2, 1'b0, 32'h4, 32'hDEADBEEF};
    model_req(r, e_rd, e_flt, e_lat);
    issue(r, g_rd, g_flt, g_lat, rib, w);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h4;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset   = 1'b0;
    saw_rsp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) saw_rsp = 1'b1;
    end
    reset = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      if (bus.rsp_valid !== 1'b0) saw_rsp = 1'b1;
      n++;
      @(negedge clk);
    end
    vectors++;
    if (saw_rsp !== 1'b0 || n !== DEPTH) begin
      miscompares++;
      $display("FAIL reset_busy: got rsp_seen=%b sweep=%0d, required rsp_seen=0 sweep=%0d", saw_rsp, n, DEPTH);
    end
    model_clear();
    r = '{1'b0, 2'd2, 1'b0, 32'h4, 32'h0};
    model_req(r, e_rd, e_flt, e_lat);
    issue(r, g_rd, g_flt, g_lat, rib, w);
    vectors++;
    if (g_rd !== 32'h0 || g_rd !== e_rd || g_flt !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_erase: got rdata=%h fault=%b, required rdata=00000000 fault=0", g_rd, g_flt);
    end
  endtask

  task automatic test_random();
    req_t r;
    logic [31:0] e_rd, g_rd;
    logic e_flt, g_flt;
    int e_lat, g_lat, w;
    bit rib;
    for (int k = 0; k < 80; k++) begin
      r.we    = 1'($urandom_range(0, 1));
      r.size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r.uns   = 1'($urandom_range(0, 1));
      r.wdata = $urandom;
      r.addr  = ($urandom_range(0, 11) == 0) ? $urandom : 32'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 4) != 0 && r.size != 2'd3) r.addr = r.addr & ~((32'h1 << r.size) - 32'h1);
      model_req(r, e_rd, e_flt, e_lat);
      issue(r, g_rd, g_flt, g_lat, rib, w);
      vectors++;
      if (g_rd !== e_rd || g_flt !== e_flt || g_lat !== e_lat || rib !== 1'b0) begin
        miscompares++;
        $display("FAIL random_%0d: got rdata=%h fault=%b lat=%0d rib=%b, required rdata=%h fault=%b lat=%0d rib=0",
                 k, g_rd, g_flt, g_lat, rib, e_rd, e_flt, e_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_merge();
    test_extend();
    test_back_to_back();
    test_faults();
    test_reset_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
